// File: rtl/pipe_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_if
// Bundle between the hazard/EX side and the front-pipeline controller.
//   Requests : iw_stall, iw_branch_taken, iw_branch_tgt[ADDR_W], iw_halt
//   Controls : ow_pc_en, ow_ifid_en, ow_ifid_flush, ow_idex_bubble,
//              ow_redirect, ow_redirect_pc[ADDR_W], ow_state[3]
//   Optional : ow_stall_cnt[16], ow_flush_cnt[16] when PIPECTRL_STATS_EN
//              is defined.
// Modports: master = request source (bench / core top),
//           slave  = pipe_ctrl.
// ---------------------------------------------------------------------------
interface pipe_ctrl_if #(
  parameter int ADDR_W = 24
);
  logic              iw_stall;
  logic              iw_branch_taken;
  logic [ADDR_W-1:0] iw_branch_tgt;
  logic              iw_halt;
  logic              ow_pc_en;
  logic              ow_ifid_en;
  logic              ow_ifid_flush;
  logic              ow_idex_bubble;
  logic              ow_redirect;
  logic [ADDR_W-1:0] ow_redirect_pc;
  logic [2:0]        ow_state;
`ifdef PIPECTRL_STATS_EN
  logic [15:0]       ow_stall_cnt;
  logic [15:0]       ow_flush_cnt;

  modport master (
    output iw_stall, iw_branch_taken, iw_branch_tgt, iw_halt,
    input  ow_pc_en, ow_ifid_en, ow_ifid_flush, ow_idex_bubble,
           ow_redirect, ow_redirect_pc, ow_state, ow_stall_cnt, ow_flush_cnt
  );
  modport slave (
    input  iw_stall, iw_branch_taken, iw_branch_tgt, iw_halt,
    output ow_pc_en, ow_ifid_en, ow_ifid_flush, ow_idex_bubble,
           ow_redirect, ow_redirect_pc, ow_state, ow_stall_cnt, ow_flush_cnt
  );
`else
  modport master (
    output iw_stall, iw_branch_taken, iw_branch_tgt, iw_halt,
    input  ow_pc_en, ow_ifid_en, ow_ifid_flush, ow_idex_bubble,
           ow_redirect, ow_redirect_pc, ow_state
  );
  modport slave (
    input  iw_stall, iw_branch_taken, iw_branch_tgt, iw_halt,
    output ow_pc_en, ow_ifid_en, ow_ifid_flush, ow_idex_bubble,
           ow_redirect, ow_redirect_pc, ow_state
  );
`endif
endinterface

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
// Front-pipeline controller. Turns the hazard unit's stall request, the
// EX-stage taken-branch redirect and a halt request into enable / flush /
// bubble controls for the PC register, the IF/ID latch and the ID/EX latch.
// All controls are combinational from the current state and the requests,
// so a stall reaches the enables in the same cycle.
//
// Ports
//   iw_clk        clock
//   iw_rst        asynchronous, active-high reset
//   bus (slave)   requests in: iw_stall, iw_branch_taken, iw_branch_tgt,
//                 iw_halt; controls out: ow_pc_en, ow_ifid_en,
//                 ow_ifid_flush, ow_idex_bubble, ow_redirect,
//                 ow_redirect_pc, ow_state (debug)
//
// Parameters
//   ADDR_W     PC / branch target width
//   FLUSH_CYC  cycles the front latches stay flushed after a redirect (1..7),
//              counting the redirect cycle itself
//
// Optional feature macro: PIPECTRL_STATS_EN
//   Adds saturating ow_stall_cnt / ow_flush_cnt and a redirect trace line.
// ---------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int ADDR_W    = 24,
  parameter int FLUSH_CYC = 2
) (
  input  logic        iw_clk,
  input  logic        iw_rst,
  pipe_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    RUN   = 3'd1,
    STALL = 3'd2,
    FLUSH = 3'd3,
    HALT  = 3'd4
  } state_t;

  localparam logic [2:0] FCNT_LOAD = 3'(FLUSH_CYC - 1);

  state_t            state_p0;
  state_t            state_nxt;
  logic [2:0]        fcnt_p0;
  logic [2:0]        fcnt_nxt;
  logic [ADDR_W-1:0] redirect_pc_p0;

  logic accept_br;
  logic stall_bubble;
  logic pc_en;
  logic ifid_en;
  logic ifid_flush;
  logic idex_bubble;
  logic redirect;

  // A taken branch is honoured everywhere except BOOT and illegal states;
  // an older in-flight instruction may redirect even while halted.
  always_comb begin
    accept_br = 1'b0;
    case (state_p0)
      RUN, STALL, FLUSH, HALT: accept_br = bus.iw_branch_taken;
      default:                 accept_br = 1'b0;
    endcase
  end

  // Next-state and control decode
  always_comb begin
    state_nxt    = state_p0;
    fcnt_nxt     = fcnt_p0;
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    redirect     = 1'b0;
    stall_bubble = 1'b0;

    if (accept_br) begin
      // Redirect wins over stall and halt: the stalled/halted instruction
      // is younger than the branch and gets flushed anyway.
      redirect    = 1'b1;
      pc_en       = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      fcnt_nxt    = FCNT_LOAD;
      state_nxt   = (FLUSH_CYC == 1) ? RUN : FLUSH;
    end else begin
      case (state_p0)
        BOOT: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          state_nxt   = RUN;
        end

        RUN, STALL: begin
          if (state_p0 == STALL && bus.iw_stall) begin
            // Halt is deliberately not looked at while a stall is held.
            idex_bubble  = 1'b1;
            stall_bubble = 1'b1;
          end else if (bus.iw_halt) begin
            idex_bubble = 1'b1;
            state_nxt   = HALT;
          end else if (bus.iw_stall) begin
            idex_bubble  = 1'b1;
            stall_bubble = 1'b1;
            state_nxt    = STALL;
          end else begin
            pc_en     = 1'b1;
            ifid_en   = 1'b1;
            state_nxt = RUN;
          end
        end

        FLUSH: begin
          // Stall is ignored here: the front latches hold only squashed work.
          pc_en       = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          fcnt_nxt    = (fcnt_p0 == 3'd0) ? 3'd0 : fcnt_p0 - 3'd1;
          if (fcnt_p0 <= 3'd1) begin
            state_nxt = RUN;
          end
        end

        HALT: begin
          idex_bubble = 1'b1;
          state_nxt   = bus.iw_halt ? HALT : RUN;
        end

        default: begin
          // Unreachable encodings look like BOOT and recover through it.
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          state_nxt   = BOOT;
        end
      endcase
    end
  end

  // State / flush counter / redirect target registers
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      state_p0       <= BOOT;
      fcnt_p0        <= 3'd0;
      redirect_pc_p0 <= '0;
    end else begin
      state_p0 <= state_nxt;
      fcnt_p0  <= fcnt_nxt;
      if (accept_br) begin
        redirect_pc_p0 <= bus.iw_branch_tgt;
      end
    end
  end

  assign bus.ow_pc_en       = pc_en;
  assign bus.ow_ifid_en     = ifid_en;
  assign bus.ow_ifid_flush  = ifid_flush;
  assign bus.ow_idex_bubble = idex_bubble;
  assign bus.ow_redirect    = redirect;
  // Bypass so the PC sees the new target in the redirect cycle itself.
  assign bus.ow_redirect_pc = accept_br ? bus.iw_branch_tgt : redirect_pc_p0;
  assign bus.ow_state       = state_p0;

`ifdef PIPECTRL_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] stall_cnt_p0;
  logic [15:0] flush_cnt_p0;

  // Statistics counters
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      stall_cnt_p0 <= 16'd0;
      flush_cnt_p0 <= 16'd0;
    end else begin
      if (stall_bubble) begin
        stall_cnt_p0 <= sat_inc(stall_cnt_p0);
      end
      if (accept_br) begin
        flush_cnt_p0 <= sat_inc(flush_cnt_p0);
      end
    end
  end

  always_ff @(posedge iw_clk) begin
    if (!iw_rst && accept_br) begin
      $display("PIPECTRL: redirect to %h", bus.iw_branch_tgt);
    end
  end

  assign bus.ow_stall_cnt = stall_cnt_p0;
  assign bus.ow_flush_cnt = flush_cnt_p0;
`else
  logic unused_stall_bubble;
  assign unused_stall_bubble = stall_bubble;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;
  localparam int ADDR_W    = 24;
  localparam int FLUSH_CYC = 2;

  logic iw_clk = 1'b0;
  logic iw_rst = 1'b1;
  always #5 iw_clk = ~iw_clk;

  pipe_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  pipe_ctrl #(.ADDR_W(ADDR_W), .FLUSH_CYC(FLUSH_CYC)) dut (
    .iw_clk (iw_clk),
    .iw_rst (iw_rst),
    .bus    (bus)
  );

  typedef struct packed {
    logic              pc_en;
    logic              ifid_en;
    logic              ifid_flush;
    logic              idex_bubble;
    logic              redirect;
    logic [ADDR_W-1:0] rpc;
    logic [2:0]        st;
    logic [15:0]       sc;
    logic [15:0]       fc;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  // Reference model: a handful of plain flags describing what the pipe is
  // doing, advanced by the behavioural rules one cycle at a time.
  bit                in_boot    = 1;
  int                flush_left = 0;
  bit                in_halt    = 0;
  bit                in_stall   = 0;
  logic [ADDR_W-1:0] last_pc    = '0;
  int                scnt       = 0;
  int                fcnt       = 0;

  task automatic model(input bit rst, input bit stall, input bit br,
                       input logic [ADDR_W-1:0] tgt, input bit halt,
                       output exp_t e);
    e = '0;
    if (rst) begin
      in_boot = 1; flush_left = 0; in_halt = 0; in_stall = 0;
      last_pc = '0; scnt = 0; fcnt = 0;
    end
    e.rpc = last_pc;
    e.sc  = 16'(scnt);
    e.fc  = 16'(fcnt);
    if (in_boot)             e.st = 3'd0;
    else if (flush_left > 0) e.st = 3'd3;
    else if (in_halt)        e.st = 3'd4;
    else if (in_stall)       e.st = 3'd2;
    else                     e.st = 3'd1;

    if (rst || in_boot) begin
      e.ifid_flush = 1; e.idex_bubble = 1;
      if (!rst) in_boot = 0;
    end else if (br) begin
      e.redirect = 1; e.pc_en = 1; e.ifid_flush = 1; e.idex_bubble = 1;
      e.rpc = tgt; last_pc = tgt;
      flush_left = FLUSH_CYC - 1;
      in_halt = 0; in_stall = 0;
      if (fcnt < 65535) fcnt++;
    end else if (flush_left > 0) begin
      e.pc_en = 1; e.ifid_flush = 1; e.idex_bubble = 1;
      flush_left--;
    end else if (in_halt) begin
      e.idex_bubble = 1;
      in_halt = halt;
    end else if (in_stall && stall) begin
      e.idex_bubble = 1;
      if (scnt < 65535) scnt++;
    end else begin
      in_stall = 0;
      if (halt) begin
        e.idex_bubble = 1; in_halt = 1;
      end else if (stall) begin
        e.idex_bubble = 1; in_stall = 1;
        if (scnt < 65535) scnt++;
      end else begin
        e.pc_en = 1; e.ifid_en = 1;
      end
    end
  endtask

  task automatic cycle(input bit rst, input bit stall, input bit br,
                       input logic [ADDR_W-1:0] tgt, input bit halt);
    exp_t e;
    @(posedge iw_clk);
    #1;
    iw_rst              = rst;
    bus.iw_stall        = stall;
    bus.iw_branch_taken = br;
    bus.iw_branch_tgt   = tgt;
    bus.iw_halt         = halt;
    model(rst, stall, br, tgt, halt, e);
    q.push_back(e);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, '0, 0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h, want %h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: compares the DUT against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge iw_clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc_en",       32'(bus.ow_pc_en),       32'(e.pc_en));
        chk("ifid_en",     32'(bus.ow_ifid_en),     32'(e.ifid_en));
        chk("ifid_flush",  32'(bus.ow_ifid_flush),  32'(e.ifid_flush));
        chk("idex_bubble", 32'(bus.ow_idex_bubble), 32'(e.idex_bubble));
        chk("redirect",    32'(bus.ow_redirect),    32'(e.redirect));
        chk("redirect_pc", 32'(bus.ow_redirect_pc), 32'(e.rpc));
        chk("state",       32'(bus.ow_state),       32'(e.st));
`ifdef PIPECTRL_STATS_EN
        chk("stall_cnt",   32'(bus.ow_stall_cnt),   32'(e.sc));
        chk("flush_cnt",   32'(bus.ow_flush_cnt),   32'(e.fc));
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.iw_stall        = 1'b0;
    bus.iw_branch_taken = 1'b0;
    bus.iw_branch_tgt   = '0;
    bus.iw_halt         = 1'b0;

    // Reset release: one BOOT cycle, then RUN
    cycle(1, 0, 0, '0, 0);
    cycle(1, 0, 0, '0, 0);
    idle(3);
    // Stall for two cycles, RUN resumes on the third
    cycle(0, 1, 0, '0, 0);
    cycle(0, 1, 0, '0, 0);
    idle(2);
    // Branch with bypassed target and two flush cycles
    cycle(0, 0, 1, 24'h000123, 0);
    idle(3);
    // Branch coinciding with a stall; stall held through FLUSH
    cycle(0, 1, 1, 24'h00ABCD, 0);
    cycle(0, 1, 0, '0, 0);
    cycle(0, 1, 0, '0, 0);
    cycle(0, 0, 0, '0, 0);
    idle(1);
    // Halt for five cycles with a branch in the third
    cycle(0, 0, 0, '0, 1);
    cycle(0, 0, 0, '0, 1);
    cycle(0, 0, 1, 24'h345678, 1);
    cycle(0, 0, 0, '0, 1);
    cycle(0, 0, 0, '0, 1);
    idle(3);
    // Halt requested during a stall is deferred
    cycle(0, 1, 0, '0, 0);
    cycle(0, 1, 0, '0, 1);
    cycle(0, 0, 0, '0, 1);
    idle(3);
    // Reset mid-FLUSH and mid-STALL
    cycle(0, 0, 1, 24'hFFFFFF, 0);
    cycle(1, 0, 0, '0, 0);
    idle(3);
    cycle(0, 1, 0, '0, 0);
    cycle(1, 1, 0, '0, 0);
    idle(3);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(bit'($urandom_range(0, 249) == 0),
            bit'($urandom_range(0, 2) == 0),
            bit'($urandom_range(0, 7) == 0),
            ADDR_W'($urandom),
            bit'($urandom_range(0, 5) == 0));
    end
    idle(2);
    @(posedge iw_clk);
    @(posedge iw_clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
